// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Shared receiver types and oversampling constants for the UART.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int         OVERSAMPLE = 8;
  localparam logic [2:0] MID_TICK   = 3'd3;
  localparam logic [2:0] LAST_TICK  = 3'(OVERSAMPLE - 1);
  localparam int         DATA_BITS  = 8;
  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_rx_if
// Brief     : Serial line, oversample tick and host holding-register handshake.
// Revision  : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
  import uart_pkg::*;

  logic                 bclkx8;
  logic                 rxd;
  logic                 rd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rdrf;
  logic                 fe;
  logic                 oe;
  logic                 pe;

  modport master (
    output bclkx8, rxd, rd,
    input  rx_data, rdrf, fe, oe, pe
  );

  modport slave (
    input  bclkx8, rxd, rd,
    output rx_data, rdrf, fe, oe, pe
  );

endinterface : uart_rx_if
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Brief    : Two-flop synchronizer for asynchronous inputs, settable reset value.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8x-oversampled UART receiver, 8N1 by default; define
//            UART_RX_PARITY_EN for 8E1/8O1 (sense from PARITY_ODD).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic     clk,
  input  logic     rstb,
  uart_rx_if.slave bus
);
  import uart_pkg::*;

  rx_state_t            r_state, w_state_nxt;
  logic [2:0]           r_cnt, w_cnt_nxt;
  logic [2:0]           r_bidx, w_bidx_nxt;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_nxt;
  logic [DATA_BITS-1:0] r_data, w_data_nxt;
  logic                 r_rdrf, w_rdrf_nxt;
  logic                 r_fe, w_fe_nxt;
  logic                 r_oe, w_oe_nxt;
  logic                 r_brk_wait, w_brk_wait_nxt;
  logic                 w_rxs;
  logic                 w_tick;
`ifdef UART_RX_PARITY_EN
  logic                 r_par, w_par_nxt;
  logic                 r_pe, w_pe_nxt;
`endif

  uart_sync2 #(.RESET_VAL(1'b1)) u_rxd_sync (
    .clk  (clk),
    .rstb (rstb),
    .d    (bus.rxd),
    .q    (w_rxs)
  );

  assign w_tick = bus.bclkx8;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bidx_nxt     = r_bidx;
    w_shreg_nxt    = r_shreg;
    w_data_nxt     = r_data;
    w_rdrf_nxt     = r_rdrf & ~bus.rd;
    w_fe_nxt       = r_fe   & ~bus.rd;
    w_oe_nxt       = r_oe   & ~bus.rd;
    w_brk_wait_nxt = r_brk_wait;
`ifdef UART_RX_PARITY_EN
    w_par_nxt      = r_par;
    w_pe_nxt       = r_pe   & ~bus.rd;
`endif

    if (w_tick) begin
      w_cnt_nxt = r_cnt + 3'd1;
      case (r_state)
        IDLE: begin
          w_cnt_nxt = 3'd0;
          if (r_brk_wait) begin
            if (w_rxs) w_brk_wait_nxt = 1'b0;
          end else if (!w_rxs) begin
            // The detect tick is position 0 of the start bit, so the
            // mid-bit check lands MID_TICK ticks after detection.
            w_state_nxt = START;
            w_cnt_nxt   = 3'd1;
          end
        end
        START: begin
          if (r_cnt == MID_TICK) begin
            if (w_rxs) begin
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = DATA;
              w_cnt_nxt   = 3'd0;
              w_bidx_nxt  = 3'd0;
            end
          end
        end
        DATA: begin
          if (r_cnt == LAST_TICK) begin
            w_shreg_nxt = {w_rxs, r_shreg[DATA_BITS-1:1]};
            w_bidx_nxt  = r_bidx + 3'd1;
            if (r_bidx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = PARITY;
`else
              w_state_nxt = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (r_cnt == LAST_TICK) begin
            w_par_nxt   = w_rxs;
            w_state_nxt = STOP;
          end
        end
`endif
        STOP: begin
          if (r_cnt == LAST_TICK) begin
            // Load beats a same-cycle read: rdrf stays set, overrun is not flagged.
            w_data_nxt  = r_shreg;
            w_rdrf_nxt  = 1'b1;
            w_fe_nxt    = w_fe_nxt | ~w_rxs;
            w_oe_nxt    = w_oe_nxt | (r_rdrf & ~bus.rd);
`ifdef UART_RX_PARITY_EN
            w_pe_nxt    = w_pe_nxt | ((^r_shreg) ^ r_par ^ PARITY_ODD);
`endif
            if (!w_rxs) w_brk_wait_nxt = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_bidx     <= 3'd0;
      r_shreg    <= '0;
      r_data     <= '0;
      r_rdrf     <= 1'b0;
      r_fe       <= 1'b0;
      r_oe       <= 1'b0;
      r_brk_wait <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par      <= 1'b0;
      r_pe       <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bidx     <= w_bidx_nxt;
      r_shreg    <= w_shreg_nxt;
      r_data     <= w_data_nxt;
      r_rdrf     <= w_rdrf_nxt;
      r_fe       <= w_fe_nxt;
      r_oe       <= w_oe_nxt;
      r_brk_wait <= w_brk_wait_nxt;
`ifdef UART_RX_PARITY_EN
      r_par      <= w_par_nxt;
      r_pe       <= w_pe_nxt;
`endif
    end
  end

  assign bus.rx_data = r_data;
  assign bus.rdrf    = r_rdrf;
  assign bus.fe      = r_fe;
  assign bus.oe      = r_oe;
`ifdef UART_RX_PARITY_EN
  assign bus.pe      = r_pe;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign bus.pe      = 1'b0;
`endif

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx with an expected-state queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_PER_TICK = 4;
  localparam int BIT_CLK      = OVERSAMPLE * CLK_PER_TICK;
  localparam bit PODD         = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN       = 1'b1;
  localparam int FRAME_BITS   = 11;
  localparam int STOP_TICKS   = 83;
`else
  localparam bit PAR_EN       = 1'b0;
  localparam int FRAME_BITS   = 10;
  localparam int STOP_TICKS   = 75;
`endif
  localparam int FRAME_CLK    = FRAME_BITS * BIT_CLK;

  typedef struct packed {
    logic [7:0] data;
    logic       rdrf;
    logic       fe;
    logic       oe;
    logic       pe;
  } exp_t;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   tick_count = 0;
  int   t0;
  exp_t sb[$];
  logic [7:0] m_data = 8'h00;
  logic m_rdrf = 1'b0, m_fe = 1'b0, m_oe = 1'b0, m_pe = 1'b0;

  uart_rx_if bus ();

  uart_rx #(.PARITY_ODD(PODD)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Oversample tick: one clk wide, every CLK_PER_TICK clocks.
  initial begin
    bus.bclkx8 = 1'b0;
    forever begin
      repeat (CLK_PER_TICK - 1) @(negedge clk);
      bus.bclkx8 = 1'b1;
      tick_count++;
      @(negedge clk);
      bus.bclkx8 = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected end of sequence");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.data = m_data;
    e.rdrf = m_rdrf;
    e.fe   = m_fe;
    e.oe   = m_oe;
    e.pe   = m_pe;
    sb.push_back(e);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop, input logic par);
    logic perr;
    perr   = (^d) ^ par ^ PODD;
    m_oe   = m_oe | m_rdrf;
    m_rdrf = 1'b1;
    m_fe   = m_fe | ~stop;
    m_pe   = m_pe | (PAR_EN & perr);
    m_data = d;
    push_model();
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_rdrf = 1'b0; m_fe = 1'b0; m_oe = 1'b0; m_pe = 1'b0;
    push_model();
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".data"}, bus.rx_data, e.data);
      check({tag, ".rdrf"}, {7'd0, bus.rdrf}, {7'd0, e.rdrf});
      check({tag, ".fe"},   {7'd0, bus.fe},   {7'd0, e.fe});
      check({tag, ".oe"},   {7'd0, bus.oe},   {7'd0, e.oe});
      check({tag, ".pe"},   {7'd0, bus.pe},   {7'd0, e.pe});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_rd(input string tag);
    @(negedge clk);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    m_rdrf = 1'b0; m_fe = 1'b0; m_oe = 1'b0; m_pe = 1'b0;
    push_model();
    check_pop(tag);
  endtask

  // Drives one frame LSB first; returns with the line idle high.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input bit expect_rx);
    bus.rxd = 1'b0;
    idle(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = d[i];
      idle(BIT_CLK);
    end
    if (PAR_EN) begin
      bus.rxd = par;
      idle(BIT_CLK);
    end
    bus.rxd = stop;
    idle(BIT_CLK);
    bus.rxd = 1'b1;
    if (expect_rx) model_frame(d, stop, par);
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ PODD;
  endfunction

  initial begin
    bus.rxd = 1'b1;
    bus.rd  = 1'b0;
    rstb    = 1'b0;
    idle(5);
    push_model();
    check_pop("reset");
    rstb = 1'b1;
    idle(20);

    // 0xA5 with stop-sample timing measured against the bench tick count
    @(posedge bus.bclkx8);
    @(negedge clk);
    t0 = tick_count;
    fork
      send_frame(8'hA5, 1'b1, good_par(8'hA5), 1'b1);
      begin
        wait (tick_count == t0 + 1 + STOP_TICKS);
        #1;
        check("a5.rdrf_before_stop_tick", {7'd0, bus.rdrf}, 8'h00);
        @(posedge clk);
        #1;
        check("a5.rdrf_after_stop_tick", {7'd0, bus.rdrf}, 8'h01);
      end
    join
    check_pop("a5");
    do_rd("a5.rd");

    // Two-tick low glitch must not start a frame
    idle(40);
    @(posedge bus.bclkx8);
    @(negedge clk);
    bus.rxd = 1'b0;
    idle(2 * CLK_PER_TICK);
    bus.rxd = 1'b1;
    idle(FRAME_CLK + 40);
    push_model();
    check_pop("glitch");

    // Back-to-back frames without a read give overrun
    send_frame(8'h3C, 1'b1, good_par(8'h3C), 1'b1);
    check_pop("b2b.first");
    send_frame(8'hC3, 1'b1, good_par(8'hC3), 1'b1);
    check_pop("b2b.second");
    do_rd("b2b.rd");

    // Framing error
    idle(40);
    send_frame(8'h55, 1'b0, good_par(8'h55), 1'b1);
    check_pop("fe55");
    idle(40);
    do_rd("fe55.rd");

    // Break: exactly one 0x00 with fe, then silence until the line goes high
    idle(40);
    bus.rxd = 1'b0;
    idle(FRAME_CLK);
    model_frame(8'h00, 1'b0, 1'b0);
    check_pop("break");
    do_rd("break.rd");
    idle(3 * FRAME_CLK);
    push_model();
    check_pop("break.hold");
    bus.rxd = 1'b1;
    idle(40);
    send_frame(8'h5A, 1'b1, good_par(8'h5A), 1'b1);
    check_pop("after_break");
    do_rd("after_break.rd");

`ifdef UART_RX_PARITY_EN
    idle(40);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    check_pop("par07.bad");
    do_rd("par07.bad.rd");
    idle(40);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check_pop("par07.good");
    do_rd("par07.good.rd");
`endif

    // Reset mid-frame at bit 4 of 0x81, held until the line is idle again
    idle(40);
    fork
      send_frame(8'h81, 1'b1, good_par(8'h81), 1'b0);
      begin
        idle(BIT_CLK * 5 + BIT_CLK / 2);
        rstb = 1'b0;
        #1;
        model_reset();
        check_pop("rst.mid");
      end
    join
    idle(10);
    rstb = 1'b1;
    idle(40);
    push_model();
    check_pop("rst.no_partial");
    send_frame(8'h81, 1'b1, good_par(8'h81), 1'b1);
    check_pop("rst.clean81");
    do_rd("rst.clean81.rd");

    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire
